// File: rtl/sa_pkg.sv
// Shared types and defaults for the systolic-array output collector.
package sa_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_FLUSH = 2'd2,
        ST_DONE  = 2'd3
    } sa_state_e;

    localparam int SA_DATA_W = 8;
    localparam int SA_PACK   = 8;
    localparam int SA_ROWS   = 32;

    // Packed words produced by one tile: ceil(rows/pack).
    function automatic int words_per_tile(input int rows, input int pack);
        return (rows + pack - 1) / pack;
    endfunction

endpackage

// File: rtl/sa_word_fifo.sv
// Synchronous first-word-fall-through FIFO holding packed words plus strobes.
// A push while full is only taken when a pop happens in the same cycle.
module sa_word_fifo #(
    parameter int WIDTH = 72,
    parameter int DEPTH = 8
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       push_i,
    input  logic [WIDTH-1:0]           push_data_i,
    input  logic                       pop_i,
    output logic [WIDTH-1:0]           pop_data_o,
    output logic                       full_o,
    output logic                       empty_o,
    output logic [$clog2(DEPTH):0]     count_o
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q, rd_ptr_q;
    logic [CW-1:0]    count_q;
    logic             do_push, do_pop;

    assign empty_o    = (count_q == '0);
    assign full_o     = (count_q == CW'(DEPTH));
    assign count_o    = count_q;
    assign pop_data_o = mem_q[rd_ptr_q];

    assign do_pop  = pop_i && !empty_o;
    assign do_push = push_i && (!full_o || do_pop);

    // Storage array; contents are don't-care until written, so no reset.
    always_ff @(posedge clk) begin
        if (do_push)
            mem_q[wr_ptr_q] <= push_data_i;
    end

    // Pointers and occupancy; depth is a power of two so pointers wrap naturally.
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
            case ({do_push, do_pop})
                2'b10:   count_q <= count_q + 1'b1;
                2'b01:   count_q <= count_q - 1'b1;
                default: count_q <= count_q;
            endcase
        end
    end

endmodule

// File: rtl/sa_out_collector.sv
// Packs the serial quantized byte stream into wide words, buffers them and
// writes them out at linearly increasing word addresses. tile_ready tells
// the SA controller there is room for a whole tile, since the stream itself
// cannot be stalled.
module sa_out_collector
    import sa_pkg::*;
#(
    parameter int DATA_W     = SA_DATA_W,
    parameter int PACK       = SA_PACK,
    parameter int ROWS       = SA_ROWS,
    parameter int FIFO_DEPTH = 8,
    parameter int ADDR_W     = 16
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   start,
    input  logic [ADDR_W-1:0]      base_addr,
    input  logic [15:0]            num_tiles,
    input  logic                   q_en,
    input  logic [DATA_W-1:0]      q_data,
    input  logic                   q_last,
    output logic                   tile_ready,
    output logic                   wr_valid,
    output logic [ADDR_W-1:0]      wr_addr,
    output logic [PACK*DATA_W-1:0] wr_data,
    output logic [PACK-1:0]        wr_strb,
    input  logic                   wr_ready,
    output logic                   busy,
    output logic                   done,
    output logic                   err_overflow,
    output logic                   err_protocol
);

    localparam int WORD_W = PACK * DATA_W;
    localparam int ENT_W  = WORD_W + PACK;
    localparam int LANE_W = (PACK > 1) ? $clog2(PACK) : 1;
    localparam int CNT_W  = $clog2(FIFO_DEPTH) + 1;
    localparam int WPT    = words_per_tile(ROWS, PACK);

    sa_state_e                      state_q;
    logic [ADDR_W-1:0]              addr_q;
    logic [15:0]                    tile_cnt_q, tile_tgt_q;
    logic [LANE_W-1:0]              lane_q;
    logic [PACK-1:0][DATA_W-1:0]    pack_q, pack_d;
    logic [PACK-1:0]                strb_q, strb_d;
    logic                           done_q, ovf_q, prot_q;

    logic                           in_run, take, push, pop;
    logic                           fifo_full, fifo_empty;
    logic [CNT_W-1:0]               fifo_cnt;
    logic [ENT_W-1:0]               fifo_head;

    assign in_run = (state_q == ST_RUN);
    assign take   = q_en && in_run;
    assign push   = take && (q_last || (lane_q == LANE_W'(PACK - 1)));
    assign pop    = wr_valid && wr_ready;

    // Current pack register with this cycle's byte merged into its lane.
    always_comb begin
        pack_d         = pack_q;
        strb_d         = strb_q;
        pack_d[lane_q] = q_data;
        strb_d[lane_q] = 1'b1;
    end

    sa_word_fifo #(
        .WIDTH (ENT_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk         (clk),
        .reset       (reset),
        .push_i      (push),
        .push_data_i ({strb_d, pack_d}),
        .pop_i       (pop),
        .pop_data_o  (fifo_head),
        .full_o      (fifo_full),
        .empty_o     (fifo_empty),
        .count_o     (fifo_cnt)
    );

    assign wr_valid = !fifo_empty;
    assign wr_data  = wr_valid ? fifo_head[WORD_W-1:0]     : '0;
    assign wr_strb  = wr_valid ? fifo_head[ENT_W-1:WORD_W] : '0;
    assign wr_addr  = addr_q;

    // Room for a full tile, plus one more word if a partial word is pending.
    assign tile_ready = in_run &&
        ((FIFO_DEPTH - int'(fifo_cnt)) >= (WPT + int'(lane_q != '0)));

    assign busy         = (state_q != ST_IDLE);
    assign done         = done_q;
    assign err_overflow = ovf_q;
    assign err_protocol = prot_q;

    // Control FSM with tile counting, write address and the done pulse.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= ST_IDLE;
            addr_q     <= '0;
            tile_cnt_q <= '0;
            tile_tgt_q <= '0;
            done_q     <= 1'b0;
        end else begin
            done_q <= (state_q == ST_DONE);
            if (pop)
                addr_q <= addr_q + 1'b1;
            case (state_q)
                ST_IDLE: begin
                    if (start) begin
                        addr_q     <= base_addr;
                        tile_tgt_q <= num_tiles;
                        tile_cnt_q <= '0;
                        state_q    <= (num_tiles == 16'd0) ? ST_DONE : ST_RUN;
                    end
                end
                ST_RUN: begin
                    if (take && q_last) begin
                        tile_cnt_q <= tile_cnt_q + 16'd1;
                        if (tile_cnt_q + 16'd1 == tile_tgt_q)
                            state_q <= ST_FLUSH;
                    end
                end
                ST_FLUSH: begin
                    if (fifo_empty)
                        state_q <= ST_DONE;
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    // Lane packing; a finished or tile-terminated word leaves a clean register.
    always_ff @(posedge clk) begin
        if (reset || (state_q == ST_IDLE && start)) begin
            pack_q <= '0;
            strb_q <= '0;
            lane_q <= '0;
        end else if (take) begin
            if (push) begin
                pack_q <= '0;
                strb_q <= '0;
                lane_q <= '0;
            end else begin
                pack_q <= pack_d;
                strb_q <= strb_d;
                lane_q <= lane_q + 1'b1;
            end
        end
    end

    // Sticky error flags, cleared only by reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            ovf_q  <= 1'b0;
            prot_q <= 1'b0;
        end else begin
            if (push && fifo_full && !pop) ovf_q  <= 1'b1;
            if (q_en && !in_run)           prot_q <= 1'b1;
        end
    end

endmodule

// File: tb/tb_sa_out_collector.sv
// Bench for sa_out_collector: table of whole-layer runs plus hand sequences
// for overflow, protocol error, empty layer and reset mid-tile.
module tb_sa_out_collector;

    logic        clk = 1'b0;
    logic        reset, start, q_en, q_last, wr_ready;
    logic [15:0] base_addr, num_tiles;
    logic [7:0]  q_data;
    logic        tile_ready, wr_valid, busy, done, err_overflow, err_protocol;
    logic [15:0] wr_addr;
    logic [63:0] wr_data;
    logic [7:0]  wr_strb;

    sa_out_collector dut (
        .clk(clk), .reset(reset), .start(start), .base_addr(base_addr),
        .num_tiles(num_tiles), .q_en(q_en), .q_data(q_data), .q_last(q_last),
        .tile_ready(tile_ready), .wr_valid(wr_valid), .wr_addr(wr_addr),
        .wr_data(wr_data), .wr_strb(wr_strb), .wr_ready(wr_ready),
        .busy(busy), .done(done), .err_overflow(err_overflow),
        .err_protocol(err_protocol)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [15:0] addr;
        logic [63:0] data;
        logic [7:0]  strb;
    } wr_t;

    typedef struct {
        logic [15:0] base;
        int          ntiles;
        int          nbytes;
        int          mode;
        int          nwr;
    } vec_t;

    wr_t         sb[$];
    int          checks = 0, errors = 0;
    int          wr_cnt = 0, done_cnt = 0, sb_keep = 1000, rmode = 0, cyc = 0;
    logic [15:0] exp_addr;
    bit          prev_stall = 0;
    logic [15:0] prev_addr;
    logic [63:0] prev_data;
    logic [7:0]  prev_strb;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s act=%h exp=%h", nm, act, exp);
        end
    endtask

    // wr_ready pattern: 0 always ready, 1 ready one cycle in four, 2 never.
    initial begin
        wr_ready = 1'b1;
        forever begin
            @(posedge clk); #1;
            cyc++;
            case (rmode)
                0:       wr_ready = 1'b1;
                1:       wr_ready = (cyc % 4 == 0);
                default: wr_ready = 1'b0;
            endcase
        end
    end

    // Write-port monitor: scoreboard compare and hold-while-stalled check.
    always @(negedge clk) begin
        if (!reset) begin
            if (prev_stall) begin
                chk("stall_valid", wr_valid, 1);
                chk("stall_addr", wr_addr, prev_addr);
                chk("stall_data", wr_data, prev_data);
                chk("stall_strb", wr_strb, prev_strb);
            end
            if (wr_valid && wr_ready) begin
                wr_cnt++;
                if (sb.size() == 0) chk("wr_unexpected", 1, 0);
                else begin
                    wr_t e;
                    e = sb.pop_front();
                    chk("wr_addr", wr_addr, e.addr);
                    chk("wr_data", wr_data, e.data);
                    chk("wr_strb", wr_strb, e.strb);
                end
            end
            if (done) done_cnt++;
        end
        prev_stall = !reset && wr_valid && !wr_ready;
        prev_addr  = wr_addr;
        prev_data  = wr_data;
        prev_strb  = wr_strb;
    end

    task automatic do_start(input logic [15:0] b, input int nt);
        base_addr = b;
        num_tiles = 16'(nt);
        exp_addr  = b;
        start     = 1'b1;
        @(posedge clk); #1;
        start     = 1'b0;
    endtask

    // One tile of nbytes consecutive bytes; expected words go to the scoreboard.
    task automatic send_tile(input int tidx, input int nbytes, input bit lat);
        logic [63:0] w;
        logic [7:0]  s;
        int          lane;
        w = '0; s = '0; lane = 0;
        for (int b = 0; b < nbytes; b++) begin
            q_en   = 1'b1;
            q_data = 8'((tidx * nbytes + b) & 255);
            q_last = (b == nbytes - 1);
            w[lane*8 +: 8] = q_data;
            s[lane] = 1'b1;
            if (lane == 7 || b == nbytes - 1) begin
                if (sb_keep > 0) begin
                    sb.push_back('{exp_addr, w, s});
                    exp_addr = exp_addr + 16'd1;
                    sb_keep--;
                end
                w = '0; s = '0; lane = 0;
            end else lane++;
            @(posedge clk); #1;
            if (lat && b == 6) chk("lat_before_word", wr_valid, 0);
            if (lat && b == 7) chk("lat_word_valid", wr_valid, 1);
        end
        q_en = 1'b0; q_last = 1'b0;
    endtask

    task automatic wait_tile_ready();
        int n = 0;
        while (!tile_ready && n < 300) begin @(posedge clk); #1; n++; end
        if (!tile_ready) chk("tile_ready_timeout", 0, 1);
    endtask

    task automatic wait_done();
        int n = 0;
        while (!done && n < 2000) begin @(posedge clk); #1; n++; end
        if (!done) chk("done_timeout", 0, 1);
    endtask

    vec_t vt[5];

    initial begin
        vt[0] = '{16'h0100, 1, 32, 0, 4};   // full tile, default shape
        vt[1] = '{16'h0040, 1, 13, 0, 2};   // partial last word, strb 0x1F
        vt[2] = '{16'h0500, 3, 32, 1, 12};  // backpressure 1-in-4
        vt[3] = '{16'hFFFF, 1, 16, 0, 2};   // address wrap
        vt[4] = '{16'h0020, 2, 20, 0, 6};   // two short tiles, 8+8+4 each

        reset = 1'b1; start = 1'b0; q_en = 1'b0; q_last = 1'b0; q_data = '0;
        base_addr = '0; num_tiles = '0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_wr_valid", wr_valid, 0);
        chk("rst_wr_addr", wr_addr, 0);
        chk("rst_wr_data", wr_data, 0);
        chk("rst_wr_strb", wr_strb, 0);
        chk("rst_tile_ready", tile_ready, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_errs", {err_overflow, err_protocol}, 0);
        reset = 1'b0;
        @(posedge clk); #1;

        for (int v = 0; v < 5; v++) begin
            rmode = vt[v].mode;
            wr_cnt = 0; done_cnt = 0;
            do_start(vt[v].base, vt[v].ntiles);
            chk("busy_after_start", busy, 1);
            for (int t = 0; t < vt[v].ntiles; t++) begin
                wait_tile_ready();
                send_tile(t, vt[v].nbytes, (v == 0 && t == 0));
            end
            wait_done();
            chk("done_busy_low", busy, 0);
            repeat (3) @(posedge clk);
            #1;
            chk("vec_writes", wr_cnt, vt[v].nwr);
            chk("vec_done_once", done_cnt, 1);
            chk("vec_sb_empty", sb.size(), 0);
            chk("vec_no_ovf", err_overflow, 0);
        end
        rmode = 0;

        // Empty layer: done two cycles after start, no writes.
        wr_cnt = 0;
        do_start(16'h0010, 0);
        chk("nt0_busy", busy, 1);
        chk("nt0_done_early", done, 0);
        @(posedge clk); #1;
        chk("nt0_done", done, 1);
        @(posedge clk); #1;
        chk("nt0_done_pulse", done, 0);
        chk("nt0_no_writes", wr_cnt, 0);

        // Stream byte while idle: flagged and ignored.
        q_en = 1'b1; q_data = 8'hAA; q_last = 1'b1;
        @(posedge clk); #1;
        q_en = 1'b0; q_last = 1'b0;
        chk("prot_flag", err_protocol, 1);
        chk("prot_no_write", wr_valid, 0);
        @(posedge clk); #1;
        chk("prot_still_idle", {busy, wr_valid}, 0);

        // Overflow: 12 words into depth 8 with the port stalled.
        rmode = 2;
        @(posedge clk); #1;
        wr_cnt = 0; done_cnt = 0; sb_keep = 8;
        do_start(16'h0200, 3);
        send_tile(0, 32, 0);
        chk("ovf_tr_half", tile_ready, 1);
        send_tile(1, 32, 0);
        chk("ovf_tr_full", tile_ready, 0);
        chk("ovf_not_yet", err_overflow, 0);
        send_tile(2, 32, 0);
        chk("ovf_flag", err_overflow, 1);
        chk("ovf_count", 64'(dut.u_fifo.count_o), 8);
        rmode = 0;
        wait_done();
        repeat (2) @(posedge clk);
        #1;
        chk("ovf_writes", wr_cnt, 8);
        chk("ovf_sticky", err_overflow, 1);
        chk("ovf_sb_empty", sb.size(), 0);
        sb_keep = 1000;

        // Reset in the middle of a tile with data queued.
        rmode = 2;
        @(posedge clk); #1;
        do_start(16'h0300, 1);
        for (int b = 0; b < 12; b++) begin
            q_en = 1'b1; q_data = 8'(b); q_last = 1'b0;
            @(posedge clk); #1;
        end
        q_en = 1'b0;
        chk("mid_wr_valid", wr_valid, 1);
        reset = 1'b1;
        @(posedge clk); #1;
        chk("mr_wr_valid", wr_valid, 0);
        chk("mr_wr_addr", wr_addr, 0);
        chk("mr_wr_data", wr_data, 0);
        chk("mr_wr_strb", wr_strb, 0);
        chk("mr_tile_ready", tile_ready, 0);
        chk("mr_busy_done", {busy, done}, 0);
        chk("mr_errs", {err_overflow, err_protocol}, 0);
        reset = 1'b0;
        sb.delete();
        rmode = 0;
        repeat (2) @(posedge clk);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
